// File: rtl/sum_pkg.sv
// Shared constants and state type for the serial adder datapath
// (collector and upstream operand serializer).
package sum_pkg;

    localparam int N  = 256;
    localparam int W  = 2;
    localparam int CC = N / W;
    localparam int IW = $clog2(CC);

    localparam logic [IW-1:0] DIG_LAST = IW'(CC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

endpackage : sum_pkg

// File: rtl/sum_digit_cnt.sv
// Digit index counter: clear, enable, and terminal-count flag at the last digit.
// Wraps to zero on the enabled terminal-count cycle.
module sum_digit_cnt
    import sum_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [IW-1:0] cnt,
    output logic          tc
);

    logic [IW-1:0] cnt_q;
    logic [IW-1:0] cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == DIG_LAST);

    // next count: clear dominates, then increment with wrap at the last digit
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : sum_digit_cnt

// File: rtl/sum_collect.sv
// Collector for the bit-serial adder: shifts in one sum digit per cycle
// (LSB digit first), presents the N-bit result with valid/ready, and
// sequences the adder via carry_clr and dig_idx.
//
// state   | meaning
// IDLE    | no operation; waiting for start
// COLLECT | shifting in digits, dig_idx = current digit
// HOLD    | result valid on sum_out, waiting for out_ready
module sum_collect
    import sum_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  c_in,
    output logic          carry_clr,
    output logic [IW-1:0] dig_idx,
    output logic          busy,
    output logic [N-1:0]  sum_out,
    output logic          out_valid,
    input  logic          out_ready
);

    state_e        state_q;
    state_e        state_d;
    logic [N-1:0]  sum_q;
    logic [N-1:0]  sum_d;
    logic          accept;
    logic          cnt_clr;
    logic          cnt_en;
    logic [IW-1:0] cnt;
    logic          cnt_tc;

    sum_digit_cnt u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    // a new operation starts from IDLE, or from HOLD once the result is taken
    assign accept    = start & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
    // the adder's carry flop is cleared during reset and in the accept cycle,
    // so its carry is zero for digit 0
    assign carry_clr = rst | accept;

    assign busy      = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign dig_idx   = (state_q == COLLECT) ? cnt : '0;
    assign sum_out   = sum_q;

    // next state, result shift and counter control
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = COLLECT;
                    cnt_clr = 1'b1;
                end
            end
            COLLECT: begin
                sum_d  = {c_in, sum_q[N-1:W]};
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        state_d = COLLECT;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
        end
    end

endmodule : sum_collect

// File: tb/tb_sum_collect.sv
// Bench for sum_collect: drives it from a behavioural bit-serial adder and
// compares each result with the plain N-bit sum of the operands.
module tb_sum_collect;
    import sum_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  c_in;
    logic          carry_clr;
    logic [IW-1:0] dig_idx;
    logic          busy;
    logic [N-1:0]  sum_out;
    logic          out_valid;
    logic          out_ready;

    logic [N-1:0]  op_a = '0;
    logic [N-1:0]  op_b = '0;
    logic          carry_q = 1'b0;
    logic [W:0]    dsum;
    logic          ovr = 1'b0;
    logic [W-1:0]  rnd_dig = '0;

    int n_chk  = 0;
    int n_pass = 0;

    sum_collect dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .c_in      (c_in),
        .carry_clr (carry_clr),
        .dig_idx   (dig_idx),
        .busy      (busy),
        .sum_out   (sum_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // serial adder: digit of a and b selected by dig_idx, plus stored carry
    always_comb begin
        dsum = {1'b0, op_a[dig_idx*W +: W]} + {1'b0, op_b[dig_idx*W +: W]}
             + {{W{1'b0}}, carry_q};
        c_in = ovr ? rnd_dig : dsum[W-1:0];
    end

    always @(posedge clk) begin
        carry_q <= carry_clr ? 1'b0 : dsum[W];
    end

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] rand_n();
        logic [N-1:0] r;
        for (int i = 0; i < N / 32; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    // Launch an operation (from IDLE or HOLD) and follow it to the result.
    // mid_idx >= 0 pulses start while dig_idx equals it.
    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input int mid_idx);
        int k;
        int dig_err;
        int clr_cnt;
        logic [N-1:0] exp_sum;
        exp_sum   = a + b;
        ovr       = 1'b0;
        op_a      = a;
        op_b      = b;
        start     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, "_clr_accept"}, N'(carry_clr), N'(1));
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        k       = 1;
        dig_err = 0;
        clr_cnt = 0;
        while (!out_valid && k <= CC + 10) begin
            if (int'(dig_idx) != k - 1 || !busy) dig_err++;
            if (carry_clr) clr_cnt++;
            start = (mid_idx >= 0 && int'(dig_idx) == mid_idx) ? 1'b1 : 1'b0;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, N'(k), N'(CC + 1));
        chk({tag, "_dig_seq"}, N'(dig_err), N'(0));
        chk({tag, "_clr_during"}, N'(clr_cnt), N'(0));
        chk({tag, "_sum"}, sum_out, exp_sum);
    endtask

    // Release the held result without starting a new one
    task automatic drain(input string tag);
        out_ready = 1'b1;
        start     = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, N'(out_valid), N'(0));
    endtask

    // Stay in HOLD under backpressure while start and c_in wiggle
    task automatic hold_cycles(input string tag, input int n, input logic [N-1:0] exp_sum);
        int errs;
        errs      = 0;
        ovr       = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            start   = 1'($urandom);
            rnd_dig = W'($urandom);
            #1;
            if (carry_clr) errs++;
            @(negedge clk);
            if (sum_out !== exp_sum || !out_valid || busy) errs++;
        end
        start = 1'b0;
        ovr   = 1'b0;
        chk({tag, "_hold_stable"}, N'(errs), N'(0));
    endtask

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] pat5;
        int errs;
        int guard;

        rst       = 1'b1;
        start     = 1'b1;
        out_ready = 1'b0;
        errs      = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!carry_clr || out_valid || busy) errs++;
        end
        chk("reset_outputs", N'(errs), N'(0));
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("reset_busy", N'(busy), N'(0));
        chk("reset_valid", N'(out_valid), N'(0));
        chk("reset_sum", sum_out, '0);
        chk("reset_idx", N'(dig_idx), N'(0));

        run_op("one_plus_one", N'(1), N'(1), -1);
        drain("one_plus_one");

        run_op("wrap", '1, N'(1), -1);
        drain("wrap");

        for (int i = 0; i < N / 4; i++) pat5[i*4 +: 4] = 4'h5;
        run_op("alt", pat5, ~pat5, -1);
        hold_cycles("alt", 20, '1);
        a = rand_n();
        b = rand_n();
        run_op("b2b", a, b, -1);
        drain("b2b");

        run_op("mid_start", rand_n(), rand_n(), 50);
        drain("mid_start");

        op_a      = rand_n();
        op_b      = rand_n();
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (dig_idx != IW'(64) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_mid_reach", N'(dig_idx), N'(64));
        rst   = 1'b1;
        start = 1'b1;
        #1;
        chk("rst_mid_clr", N'(carry_clr), N'(1));
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_mid_valid", N'(out_valid), N'(0));
        chk("rst_mid_busy", N'(busy), N'(0));
        chk("rst_mid_sum", sum_out, '0);
        run_op("after_rst", N'(7), N'(9), -1);
        drain("after_rst");

        for (int r = 0; r < 6; r++) begin
            a = rand_n();
            b = rand_n();
            if (r == 0) begin
                a = '1;
                b = '1;
            end
            run_op("rand", a, b, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, CC - 1)) : -1);
            hold_cycles("rand", int'($urandom_range(1, 5)), a + b);
            if ($urandom_range(0, 1) == 1) drain("rand");
        end
        drain("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_sum_collect
